// File: rtl/cla_alu_pipelined.sv
// WIDTH-bit two-level carry-lookahead ALU behind a 2-stage valid/ready pipeline.
// S1 holds conditioned operands and group P/G; S2 holds resolved result and flags.
module cla_alu_pipelined #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_alu_op,
    input  logic             in_c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_c_last,
    output logic             out_overflow,
    output logic             out_zero,
    output logic             out_p,
    output logic             out_g,
    output logic             out_op_err
);

    localparam int NG = WIDTH / GROUP;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_ADC = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    generate
        if (GROUP < 1 || WIDTH < GROUP || (WIDTH % GROUP) != 0) begin : g_bad_params
            $error("cla_alu_pipelined: WIDTH must be a non-zero multiple of GROUP");
        end
    endgenerate

    // ---------------- handshake ----------------
    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic s2_advance, accept, s1_to_s2;

    assign s2_advance = !s2_valid_q | out_ready;
    assign in_ready   = !s1_valid_q | s2_advance;
    assign accept     = in_valid & in_ready;
    assign s1_to_s2   = s1_valid_q & s2_advance;

    // ---------------- operand conditioning + first-level lookahead ----------------
    logic             is_sub;
    logic [WIDTH-1:0] b_cond;
    logic             c0;
    logic [NG-1:0]    grp_p, grp_g;

    always_comb begin : s0_cll
        logic gp, gg;
        is_sub = in_alu_op[2] & in_alu_op[1];
        b_cond = is_sub ? ~in_b : in_b;
        c0     = is_sub | ((in_alu_op == OP_ADC) & in_c_in);
        grp_p  = '0;
        grp_g  = '0;
        gp     = 1'b1;
        gg     = 1'b0;
        for (int j = 0; j < NG; j++) begin
            gp = 1'b1;
            gg = 1'b0;
            for (int k = 0; k < GROUP; k++) begin
                gg = (in_a[j*GROUP+k] & b_cond[j*GROUP+k])
                   | ((in_a[j*GROUP+k] | b_cond[j*GROUP+k]) & gg);
                gp = gp & (in_a[j*GROUP+k] | b_cond[j*GROUP+k]);
            end
            grp_p[j] = gp;
            grp_g[j] = gg;
        end
    end

    // ---------------- S1 registers ----------------
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             c0_q, c0_d;
    logic [2:0]       op_q, op_d;
    logic [NG-1:0]    grp_p_q, grp_p_d, grp_g_q, grp_g_d;

    always_comb begin
        s1_valid_d = accept | (s1_valid_q & !s2_advance);
        a_d        = accept ? in_a      : a_q;
        b_d        = accept ? b_cond    : b_q;
        c0_d       = accept ? c0        : c0_q;
        op_d       = accept ? in_alu_op : op_q;
        grp_p_d    = accept ? grp_p     : grp_p_q;
        grp_g_d    = accept ? grp_g     : grp_g_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            c0_q       <= 1'b0;
            op_q       <= '0;
            grp_p_q    <= '0;
            grp_g_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            a_q        <= a_d;
            b_q        <= b_d;
            c0_q       <= c0_d;
            op_q       <= op_d;
            grp_p_q    <= grp_p_d;
            grp_g_q    <= grp_g_d;
        end
    end

    // ---------------- second-level lookahead and in-group carries ----------------
    logic [WIDTH-1:0] sum;
    logic             c_msb_in, c_msb_out, blk_p, blk_g;

    always_comb begin : s1_carries
        logic [WIDTH:0] c;
        logic [NG:0]    cg;
        logic           bg;
        c     = '0;
        cg    = '0;
        cg[0] = c0_q;
        bg    = 1'b0;
        for (int j = 0; j < NG; j++) begin
            cg[j+1] = grp_g_q[j] | (grp_p_q[j] & cg[j]);
            bg      = grp_g_q[j] | (grp_p_q[j] & bg);
        end
        for (int j = 0; j < NG; j++) begin
            c[j*GROUP] = cg[j];
            for (int k = 1; k < GROUP; k++) begin
                c[j*GROUP+k] = (a_q[j*GROUP+k-1] & b_q[j*GROUP+k-1])
                             | ((a_q[j*GROUP+k-1] | b_q[j*GROUP+k-1]) & c[j*GROUP+k-1]);
            end
        end
        c[WIDTH]  = cg[NG];
        sum       = a_q ^ b_q ^ c[WIDTH-1:0];
        c_msb_in  = c[WIDTH-1];
        c_msb_out = c[WIDTH];
        blk_p     = &grp_p_q;
        blk_g     = bg;
    end

    // ---------------- result / flag select ----------------
    logic [WIDTH-1:0] res;
    logic             res_c, res_v, res_z, res_p, res_g, res_err, ovf_raw;

    always_comb begin
        ovf_raw = c_msb_in ^ c_msb_out;
        res     = '0;
        res_c   = 1'b0;
        res_v   = 1'b0;
        res_p   = 1'b0;
        res_g   = 1'b0;
        res_err = 1'b0;
        case (op_q)
            OP_AND: res = a_q & b_q;
            OP_OR:  res = a_q | b_q;
            OP_ADD, OP_ADC, OP_SUB: begin
                res   = sum;
                res_c = c_msb_out;
                res_v = ovf_raw;
                res_p = blk_p;
                res_g = blk_g;
            end
            OP_SLT: res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf_raw};
            default: res_err = 1'b1;
        endcase
        // an illegal opcode reports only op_err, so zero is suppressed too
        res_z = !res_err & (res == '0);
    end

    // ---------------- S2 registers ----------------
    logic [WIDTH-1:0] result_q, result_d;
    logic             c_last_q, c_last_d, ovf_q, ovf_d, zero_q, zero_d;
    logic             p_q, p_d, g_q, g_d, op_err_q, op_err_d;

    always_comb begin
        s2_valid_d = s2_advance ? s1_valid_q : s2_valid_q;
        result_d   = s1_to_s2 ? res     : result_q;
        c_last_d   = s1_to_s2 ? res_c   : c_last_q;
        ovf_d      = s1_to_s2 ? res_v   : ovf_q;
        zero_d     = s1_to_s2 ? res_z   : zero_q;
        p_d        = s1_to_s2 ? res_p   : p_q;
        g_d        = s1_to_s2 ? res_g   : g_q;
        op_err_d   = s1_to_s2 ? res_err : op_err_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid_q <= 1'b0;
            result_q   <= '0;
            c_last_q   <= 1'b0;
            ovf_q      <= 1'b0;
            zero_q     <= 1'b0;
            p_q        <= 1'b0;
            g_q        <= 1'b0;
            op_err_q   <= 1'b0;
        end else begin
            s2_valid_q <= s2_valid_d;
            result_q   <= result_d;
            c_last_q   <= c_last_d;
            ovf_q      <= ovf_d;
            zero_q     <= zero_d;
            p_q        <= p_d;
            g_q        <= g_d;
            op_err_q   <= op_err_d;
        end
    end

    assign out_valid    = s2_valid_q;
    assign out_result   = result_q;
    assign out_c_last   = c_last_q;
    assign out_overflow = ovf_q;
    assign out_zero     = zero_q;
    assign out_p        = p_q;
    assign out_g        = g_q;
    assign out_op_err   = op_err_q;

endmodule

// File: doc/cla_alu_pipelined.md
Name: cla_alu_pipelined

Overview:
- Parametrised WIDTH-bit carry-lookahead ALU with a 2-stage valid/ready pipeline.
- Successor to the fixed 4-bit CLA slice. Adds:
  - generic width and lookahead group size
  - registered status flags
  - add-with-carry (ADC) and set-less-than (SLT)
  - backpressure
- Sits between operand fetch and writeback in the datapath.
- Block-level P/G outputs are exported for cascading.

Parameters:
- WIDTH, 16, operand/result width. Must be a multiple of GROUP; otherwise elaboration error.
- GROUP, 4, bits per lookahead group (first-level CLL size).

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B (raw; inverted internally for SUB/SLT)
- in_alu_op  in  3  operation select
- in_c_in  in  1  carry-in, used by ADC only
- out_valid  out  1  result beat valid
- out_ready  in  1  consumer accepts beat
- out_result  out  WIDTH  result
- out_c_last  out  1  carry out of MSB
- out_overflow  out  1  signed overflow (ADD/ADC/SUB only)
- out_zero  out  1  out_result == 0
- out_p  out  1  block propagate, AND of all group P
- out_g  out  1  block generate
- out_op_err  out  1  illegal opcode flag

Behaviour:
- Opcodes:
  - 000 AND
  - 001 OR
  - 010 ADD (c0=0)
  - 011 ADC (c0=in_c_in)
  - 110 SUB (b=~in_b, c0=1)
  - 111 SLT (SUB internally; result = {0..., sign(a-b) XOR overflow})
  - 100 and 101 are illegal: out_result=0, all arithmetic flags 0, out_op_err=1.
- Bit-level propagate/generate: p=a|b, g=a&b, both computed on the conditioned b. Group P/G and carries follow standard two-level lookahead (GROUP-input CLL per group, second-level CLL across groups).
- For AND/OR: out_c_last, out_overflow, out_p and out_g are 0. out_zero is still valid.
- Stage 1 (S1) registers: conditioned b, a, c0, op, group P/G.
- Stage 2 (S2) registers: carries resolved, result, all flags.
- Latency: 2 cycles from accept (in_valid & in_ready at edge N) to out_valid at edge N+2, provided there is no stall.
- Throughput: 1 beat/cycle.
- Handshake:
  - in_ready = !s1_valid | s2_advance, where s2_advance = !s2_valid | out_ready.
  - S1 moves to S2 when s1_valid & s2_advance.
  - Output held stable while out_valid & !out_ready.
  - No combinational path from in_valid to out_valid. in_ready depends only on state and out_ready.
- Buffering: at most 2 beats in flight. When full (both stages valid) and out_ready=0, in_ready=0. Ordering is strictly FIFO.
- Simultaneous accept and drain while full: both occur in the same cycle and no beat is lost.
- Reset (async assert, deasserted synchronously by the system):
  - clears s1_valid and s2_valid
  - forces out_valid=0, out_result=0, all flags=0
  - in_ready=1 after reset
  - in-flight beats are discarded, including when reset is asserted mid-stall.
- Overflow = c_in_msb XOR c_out_msb.
- SLT ignores out_c_last (forced 0), out_overflow (forced 0) and out_p/out_g (forced 0).

Test Plan (WIDTH=16, GROUP=4):
- ADD 0xFFFF+0x0001 -> result 0x0000, c_last=1, zero=1, overflow=0, out_valid exactly 2 cycles after accept.
- SUB 0x8000-0x0001 -> 0x7FFF, c_last=1, overflow=1. SLT a=0xFFFF, b=0x0001 -> result 0x0001. SLT a=0x7FFF, b=0x8000 -> 0x0000.
- ADC 0x00FF+0x0000 with in_c_in=1 -> 0x0100, c_last=0. Op 100 with any operands -> result 0, op_err=1, other flags 0.
- Backpressure: issue 4 back-to-back ADDs (1+1, 2+2, 3+3, 4+4) with out_ready=0 -> in_ready drops after 2 accepts. Raise out_ready -> results 2,4,6,8 delivered in order, none dropped or duplicated.
- Full pipeline with out_ready=1 and in_valid=1 continuously -> one result per cycle, in_ready never deasserts.
- Assert reset_n=0 mid-stall with 2 beats held -> out_valid=0 immediately (async), in_ready=1. After release, no stale beats appear.
